inst_prefetch_buf: RTL
======================

Name: inst_prefetch_buf

Overview:
- Instruction-fetch front end between the core's ROM port (rom_ce_o/rom_addr_o/rom_data_i) and a variable-latency instruction memory with a request/grant/response handshake.
- Prefetches sequential words into a DEPTH-slot in-order queue and presents the word matching the core's PC.
- Requests a pipeline stall while that word is unavailable, and flushes on any PC discontinuity (branch/jump redirect).

Parameters:
- DEPTH, 4, queue slots; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- ce_i  in  1  core fetch enable (core rom_ce_o)
- addr_i  in  32  core PC (core rom_addr_o)
- stall_i  in  1  pipeline stall from ctrl; no pop while high
- inst_o  out  32  instruction for addr_i (core rom_data_i)
- inst_valid_o  out  1  inst_o valid for addr_i this cycle
- stall_req_o  out  1  fetch-not-ready stall request to ctrl
- mem_req_o  out  1  memory request valid
- mem_addr_o  out  32  request word address
- mem_gnt_i  in  1  request accepted when mem_req_o & mem_gnt_i
- mem_rvalid_i  in  1  response valid; responses return in request order, ≥1 cycle after grant
- mem_rdata_i  in  32  response data

Behaviour:
- Reset (rst=0, async):
  - all slots free; drop_cnt=0; fetch_pc=RESET_PC
  - inst_o=0, inst_valid_o=0, stall_req_o=0, mem_req_o=0, mem_addr_o=RESET_PC
- Slot state: free / allocated (addr, data pending) / filled (addr, data). Head = oldest allocated slot. used = number of allocated+filled slots.
- Issue:
  - mem_req_o = rst & ~redirect & (used + drop_cnt < DEPTH); mem_addr_o = fetch_pc.
  - On req&gnt: allocate tail slot with addr=fetch_pc; fetch_pc += 4 (32-bit wrap: 32'hFFFF_FFFC → 0).
  - Request may be withdrawn before grant (e.g. redirect); memory samples only on req&gnt.
- Response:
  - On rvalid with drop_cnt>0: data discarded; drop_cnt−1.
  - Otherwise: fills the oldest allocated slot.
  - rvalid with no outstanding request is a protocol error; ignore it and leave state unchanged.
- Hit: head filled & head.addr==addr_i & ce_i. On hit: inst_valid_o=1, inst_o=head.data; otherwise inst_o=0, inst_valid_o=0.
- Pop: hit & ~stall_i frees head at the clock edge.
- stall_req_o = ce_i & ~hit. It is 0 when ce_i=0.
- Redirect = ce_i & ~stall_i & one of:
  - head exists & head.addr≠addr_i
  - queue empty & fetch_pc≠addr_i
- On redirect, at the clock edge:
  - drop_cnt += number of allocated-unfilled slots
  - free all slots
  - fetch_pc = addr_i
  - no issue that cycle
  - first new request is next cycle
- Simultaneous events:
  - rvalid same cycle as redirect: counted against the old stream (drop_cnt computed after the fill/drop of that cycle).
  - Pop and issue same cycle: both occur; used unchanged.
  - Full (used+drop_cnt==DEPTH) with same-cycle pop: no issue this cycle; issue next cycle.
- Best-case latency, sequential stream at 1-cycle memory: one instruction per cycle. After redirect: stall ≥3 cycles (redirect, grant, response, hit next cycle) without the optional feature.
- Reset mid-transaction: all state cleared; late responses after reset deassertion are ignored as protocol error (drop_cnt=0, no slot allocated).

Optional Feature:
- INST_PREFETCH_BYPASS_EN.
- Defined: response data filling the head slot is forwarded combinationally to inst_o the same cycle when head.addr==addr_i. Hit and pop are allowed that cycle, saving one cycle after every miss.
- Undefined: filled data is visible only from the next cycle.

Test Plan:
- Reset, ce_i=1, addr_i walks 0,4,8… from RESET_PC=0; memory gnt=1, rvalid 1 cycle after grant, rdata=addr^32'hA5A5_A5A5 → inst_o matches per address, no stall after initial fill, mem_addr_o sequential.
- Redirect: core at 0x10 with 3 requests outstanding, addr_i jumps to 0x100 → drop_cnt=3, next mem_addr_o=0x100, three stale responses discarded, first inst_o=0x100^key, stall_req_o high until then.
- Backpressure: mem_gnt_i=0 for 5 cycles → mem_req_o held, mem_addr_o stable, stall_req_o=1, no slot allocated; gnt=1 resumes.
- Full: stall_i=1 for 10 cycles → issues stop at used=DEPTH (4 grants), no pop; release → pops resume in order with no loss.
- Simultaneous rvalid and redirect in the same cycle → that response dropped (drop_cnt reflects it), post-redirect data correct.
- Async reset asserted mid-stream with 2 outstanding → outputs zero immediately, fetch restarts at RESET_PC. Run with and without INST_PREFETCH_BYPASS_EN; the miss-to-hit gap differs by exactly 1 cycle.

Source files
------------

// File: rtl/inst_prefetch_buf.sv
// Instruction prefetch queue between the core ROM port and a req/gnt/rvalid memory.
// Optional define INST_PREFETCH_BYPASS_EN forwards a head-filling response to inst_o the same cycle.
module inst_prefetch_buf #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic [31:0] addr_i,
    input  logic        stall_i,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        stall_req_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW+1:0] DEPTH_C = (PW+2)'(DEPTH);
    typedef logic [PW:0] ptr_t;

    // In-order ring: [rd_ptr, fill_ptr) filled, [fill_ptr, wr_ptr) awaiting data.
    logic [31:0] slot_addr [DEPTH];
    logic [31:0] slot_data [DEPTH];
    ptr_t        rd_ptr, fill_ptr, wr_ptr;
    ptr_t        drop_cnt;
    logic [31:0] fetch_pc;

    ptr_t        used, pending;
    logic        head_exists, head_filled, bypass;
    logic        rsp_drop, rsp_fill, hit, pop, redirect, issue;
    logic [31:0] head_addr, head_data;

    assign used        = wr_ptr - rd_ptr;
    assign pending     = wr_ptr - fill_ptr;
    assign head_exists = (used != '0);
    assign head_filled = (fill_ptr != rd_ptr);
    assign head_addr   = slot_addr[rd_ptr[PW-1:0]];
    assign head_data   = head_filled ? slot_data[rd_ptr[PW-1:0]] : mem_rdata_i;

    // Responses first retire stale requests of a flushed stream; orphan responses are ignored.
    assign rsp_drop = mem_rvalid_i & (drop_cnt != '0);
    assign rsp_fill = mem_rvalid_i & (drop_cnt == '0) & (pending != '0);

`ifdef INST_PREFETCH_BYPASS_EN
    assign bypass = rsp_fill & ~head_filled;
`else
    assign bypass = 1'b0;
`endif

    assign hit      = rst & ce_i & head_exists & (head_addr == addr_i) & (head_filled | bypass);
    assign pop      = hit & ~stall_i;
    assign redirect = rst & ce_i & ~stall_i &
                      (head_exists ? (head_addr != addr_i) : (fetch_pc != addr_i));

    // In-flight stale requests still hold capacity until their responses drain.
    assign mem_req_o  = rst & ~redirect & (({1'b0, used} + {1'b0, drop_cnt}) < DEPTH_C);
    assign mem_addr_o = fetch_pc;
    assign issue      = mem_req_o & mem_gnt_i;

    assign inst_valid_o = hit;
    assign inst_o       = hit ? head_data : 32'h0;
    assign stall_req_o  = rst & ce_i & ~hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr   <= '0;
            fill_ptr <= '0;
            wr_ptr   <= '0;
            drop_cnt <= '0;
            fetch_pc <= RESET_PC;
        end else if (redirect) begin
            // This cycle's response is charged to the old stream before counting what is left.
            rd_ptr   <= '0;
            fill_ptr <= '0;
            wr_ptr   <= '0;
            drop_cnt <= drop_cnt - ptr_t'(rsp_drop) + pending - ptr_t'(rsp_fill);
            fetch_pc <= addr_i;
        end else begin
            if (issue) begin
                wr_ptr   <= wr_ptr + ptr_t'(1);
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (rsp_fill) fill_ptr <= fill_ptr + ptr_t'(1);
            if (pop)      rd_ptr   <= rd_ptr + ptr_t'(1);
            if (rsp_drop) drop_cnt <= drop_cnt - ptr_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (issue)    slot_addr[wr_ptr[PW-1:0]]   <= fetch_pc;
        if (rsp_fill) slot_data[fill_ptr[PW-1:0]] <= mem_rdata_i;
    end

endmodule
